// File: rtl/cpu_board_pkg.sv
// Shared encodings for the CPU board: run-controller FSM states and display select codes.
package cpu_board_pkg;

  typedef enum logic [1:0] {
    StPause = 2'd0,
    StRun   = 2'd1,
    StStep  = 2'd2
  } run_state_e;

  localparam logic [1:0] DispInst  = 2'b00;
  localparam logic [1:0] DispPc    = 2'b01;
  localparam logic [1:0] DispSteps = 2'b10;
  localparam logic [1:0] DispState = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability debounce and rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DB_W = 20
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic            s1, s2;
  logic            stable, stable_q;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      stable_q <= stable;
      // Any return to the accepted level restarts the stability window.
      if (s2 == stable) begin
        db_cnt <= '0;
      end else if (&db_cnt) begin
        stable <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign press = stable & ~stable_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/pause/step controller issuing a clock enable to the CPU, with step counter and display mux.
module cpu_run_ctrl
  import cpu_board_pkg::*;
#(
  parameter int unsigned DIV_W = 26,
  parameter int unsigned DB_W  = 20
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic [1:0]  sw_disp,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic        cpu_en,
  output logic [31:0] step_cnt,
  output logic [31:0] disp_data,
  output logic [1:0]  run_state
);

  logic             run_press, step_press;
  run_state_e       state;
  logic [DIV_W-1:0] div_cnt;
  logic [31:0]      step_cnt_d;

  btn_debounce #(
    .DB_W (DB_W)
  ) u_db_run (
    .clk_in (clk_in),
    .reset  (reset),
    .btn    (btn_run),
    .press  (run_press)
  );

  btn_debounce #(
    .DB_W (DB_W)
  ) u_db_step (
    .clk_in (clk_in),
    .reset  (reset),
    .btn    (btn_step),
    .press  (step_press)
  );

  // Run press takes priority over a simultaneous step press.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= StPause;
      div_cnt <= '0;
    end else begin
      unique case (state)
        StPause: begin
          div_cnt <= '0;
          if (run_press) begin
            state <= StRun;
          end else if (step_press) begin
            state <= StStep;
          end
        end
        StRun: begin
          if (run_press) begin
            state   <= StPause;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        StStep: begin
          state   <= StPause;
          div_cnt <= '0;
        end
        default: begin
          state   <= StPause;
          div_cnt <= '0;
        end
      endcase
    end
  end

  assign run_state = state;
  assign cpu_en    = (state == StStep) | ((state == StRun) & (&div_cnt));

  always_comb begin
    step_cnt_d = step_cnt;
    if (cpu_en) begin
      step_cnt_d = step_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt_d;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      disp_data <= '0;
    end else begin
      unique case (sw_disp)
        DispInst:  disp_data <= inst;
        DispPc:    disp_data <= pc;
        DispSteps: disp_data <= step_cnt;
        DispState: disp_data <= {30'b0, run_state};
        default:   disp_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DB_W=2 and DIV_W=3.
module tb_cpu_run_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        btn_run, btn_step;
  logic [1:0]  sw_disp;
  logic [31:0] pc, inst;
  logic        cpu_en;
  logic [31:0] step_cnt, disp_data;
  logic [1:0]  run_state;

  int total = 0;
  int bad = 0;
  int en_count = 0;

  cpu_run_ctrl #(
    .DIV_W (3),
    .DB_W  (2)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .sw_disp   (sw_disp),
    .pc        (pc),
    .inst      (inst),
    .cpu_en    (cpu_en),
    .step_cnt  (step_cnt),
    .disp_data (disp_data),
    .run_state (run_state)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (cpu_en === 1'b1) en_count <= en_count + 1;
  end

  // Each call advances past one rising edge; sampling happens just after the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; btn_run = 1'b0; btn_step = 1'b0;
    sw_disp = 2'b00; pc = 32'h0; inst = 32'hDEAD_BEEF;
    tick(3);
    reset = 1'b0;
    check("rst_state", {30'b0, run_state}, 32'd0);
    check("rst_en", {31'b0, cpu_en}, 32'd0);
    check("rst_cnt", step_cnt, 32'd0);
    check("rst_disp", disp_data, 32'd0);

    tick(50);
    check("idle_state", {30'b0, run_state}, 32'd0);
    check("idle_cnt", step_cnt, 32'd0);
    check("idle_pulses", en_count, 0);
    check("disp_inst", disp_data, 32'hDEAD_BEEF);

    // Single step: press sampled at edge 0, STEP at edge 6.
    btn_step = 1'b1;
    tick(6);
    check("step_e5_state", {30'b0, run_state}, 32'd0);
    check("step_e5_en", {31'b0, cpu_en}, 32'd0);
    tick(1);
    check("step_e6_state", {30'b0, run_state}, 32'd2);
    check("step_e6_en", {31'b0, cpu_en}, 32'd1);
    check("step_e6_cnt", step_cnt, 32'd0);
    tick(1);
    check("step_e7_state", {30'b0, run_state}, 32'd0);
    check("step_e7_en", {31'b0, cpu_en}, 32'd0);
    check("step_e7_cnt", step_cnt, 32'd1);
    tick(2);
    btn_step = 1'b0;
    tick(10);
    check("step_release_cnt", step_cnt, 32'd1);
    check("step_pulses", en_count, 1);

    // Bounce never stays stable long enough.
    btn_step = 1'b1; tick(1);
    btn_step = 1'b0; tick(1);
    btn_step = 1'b1; tick(1);
    btn_step = 1'b0; tick(10);
    check("bounce_state", {30'b0, run_state}, 32'd0);
    check("bounce_cnt", step_cnt, 32'd1);

    // Free run: RUN entered at edge 6, pulses when div_cnt is 7.
    btn_run = 1'b1;
    tick(7);
    check("run_enter_state", {30'b0, run_state}, 32'd1);
    check("run_enter_en", {31'b0, cpu_en}, 32'd0);
    tick(3);
    btn_run = 1'b0;
    tick(3);
    check("run_e12_en", {31'b0, cpu_en}, 32'd0);
    tick(1);
    check("run_e13_en", {31'b0, cpu_en}, 32'd1);
    check("run_e13_cnt", step_cnt, 32'd1);
    tick(1);
    check("run_e14_en", {31'b0, cpu_en}, 32'd0);
    check("run_e14_cnt", step_cnt, 32'd2);
    tick(32);
    check("run_40_cnt", step_cnt, 32'd6);
    check("run_40_state", {30'b0, run_state}, 32'd1);

    // Second press timed so RUN->PAUSE lands on the all-ones edge.
    tick(1);
    btn_run = 1'b1;
    tick(6);
    check("leave_last_state", {30'b0, run_state}, 32'd1);
    check("leave_last_en", {31'b0, cpu_en}, 32'd1);
    check("leave_last_cnt", step_cnt, 32'd6);
    tick(1);
    check("leave_state", {30'b0, run_state}, 32'd0);
    check("leave_en", {31'b0, cpu_en}, 32'd0);
    check("leave_cnt", step_cnt, 32'd7);
    tick(3);
    btn_run = 1'b0;
    tick(20);
    check("paused_cnt", step_cnt, 32'd7);
    check("paused_pulses", en_count, 7);

    // Simultaneous press: run wins, step dropped.
    btn_run = 1'b1; btn_step = 1'b1;
    tick(7);
    check("simul_state", {30'b0, run_state}, 32'd1);
    check("simul_en", {31'b0, cpu_en}, 32'd0);
    check("simul_cnt", step_cnt, 32'd7);
    tick(3);
    btn_run = 1'b0; btn_step = 1'b0;
    tick(10);
    check("simul_run_cnt", step_cnt, 32'd8);
    // Step press in RUN is ignored; only cadence pulses at rel. edges 14 and 22.
    btn_step = 1'b1;
    tick(10);
    btn_step = 1'b0;
    check("run_step_state", {30'b0, run_state}, 32'd1);
    check("run_step_cnt", step_cnt, 32'd9);

    // Display mux with one cycle of latency.
    sw_disp = 2'b01; pc = 32'h0040_0004;
    check("disp_hold", disp_data, 32'hDEAD_BEEF);
    tick(1);
    check("disp_pc", disp_data, 32'h0040_0004);
    sw_disp = 2'b11;
    tick(1);
    check("disp_state", disp_data, 32'd1);

    // Asynchronous reset while running.
    reset = 1'b1;
    #1;
    check("midrst_state", {30'b0, run_state}, 32'd0);
    check("midrst_en", {31'b0, cpu_en}, 32'd0);
    check("midrst_cnt", step_cnt, 32'd0);
    check("midrst_disp", disp_data, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("post_rst_state", {30'b0, run_state}, 32'd0);

    // Wrap: preload the counter, then issue one step.
    sw_disp = 2'b10;
    force dut.step_cnt_d = 32'hFFFF_FFFF;
    tick(1);
    release dut.step_cnt_d;
    check("wrap_preload", step_cnt, 32'hFFFF_FFFF);
    tick(1);
    check("disp_steps", disp_data, 32'hFFFF_FFFF);
    check("wrap_hold", step_cnt, 32'hFFFF_FFFF);
    btn_step = 1'b1;
    tick(7);
    check("wrap_step_state", {30'b0, run_state}, 32'd2);
    check("wrap_step_en", {31'b0, cpu_en}, 32'd1);
    tick(1);
    check("wrap_cnt", step_cnt, 32'd0);
    check("wrap_state", {30'b0, run_state}, 32'd0);
    btn_step = 1'b0;
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
